// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register index type, PC index and datapath width.
package cpu_pkg;

  localparam int REG_AW = 4;
  localparam int DW     = 32;

  typedef logic [REG_AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_PC = 4'd15;

  // Results aimed at the PC are dropped by the writeback path.
  function automatic logic is_pc(input reg_idx_t idx);
    return idx == REG_PC;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding {rd, data} load results awaiting the write port.
module wb_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly at DEPTH so a single-entry buffer also works.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; push and pop may coincide.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Writeback controller: arbitrates ALU and load results onto the single
// register_file write port and tracks which registers have writes in flight.
//
// Handshake: the load port transfers when mem_valid_i & mem_ready_o are both
// high on a rising edge; mem_valid_i/mem_rd_i/mem_data_i must stay stable while
// waiting, and mem_ready_o depends only on registered state (never on
// mem_valid_i). The ALU port has no ready and is consumed whenever valid.
module reg_writeback_ctrl #(
  parameter int DW       = 32,
  parameter int NREG     = 16,
  parameter int WB_DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          issue_valid_i,
  input  logic          issue_wr_i,
  input  logic [3:0]    issue_rd_i,
  input  logic          r1_used_i,
  input  logic [3:0]    r1_addr_i,
  input  logic          r2_used_i,
  input  logic [3:0]    r2_addr_i,
  input  logic          alu_valid_i,
  input  logic [3:0]    alu_rd_i,
  input  logic [DW-1:0] alu_data_i,
  input  logic          mem_valid_i,
  input  logic [3:0]    mem_rd_i,
  input  logic [DW-1:0] mem_data_i,
  output logic          mem_ready_o,
  output logic          stall_o,
  output logic          wr_en_o,
  output logic [3:0]    wr_addr_o,
  output logic [DW-1:0] data_o
);

  import cpu_pkg::reg_idx_t;
  import cpu_pkg::REG_PC;
  import cpu_pkg::is_pc;

  localparam int FW = DW + 4;

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic            issue_set;
  logic            alu_wr;
  logic            mem_wr;
  logic            fifo_full;
  logic            fifo_empty;
  logic [FW-1:0]   fifo_dout;
  logic            fifo_push;
  logic            fifo_pop;
  logic            direct_ld;
  logic            sel_valid;
  reg_idx_t        sel_addr;
  logic [DW-1:0]   sel_data;

  // Hazard check: any used source or the destination still awaiting a write.
  assign stall_o = issue_valid_i &
                   ((r1_used_i  & pend_q[r1_addr_i]) |
                    (r2_used_i  & pend_q[r2_addr_i]) |
                    (issue_wr_i & pend_q[issue_rd_i]));

  assign issue_set   = issue_valid_i & ~stall_o & issue_wr_i & ~is_pc(issue_rd_i);
  assign mem_ready_o = ~fifo_full;

  // A PC-targeted result is consumed but never occupies the port or the buffer.
  assign alu_wr    = alu_valid_i & ~is_pc(alu_rd_i);
  assign mem_wr    = mem_valid_i & mem_ready_o & ~is_pc(mem_rd_i);
  assign fifo_pop  = ~alu_wr & ~fifo_empty;
  assign direct_ld = mem_wr & ~alu_wr & fifo_empty;
  assign fifo_push = mem_wr & ~direct_ld;

  wb_fifo #(
    .W     (FW),
    .DEPTH (WB_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .din_i   ({mem_rd_i, mem_data_i}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Port arbitration: ALU first, then oldest buffered load, then a fresh load.
  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = alu_rd_i;
    sel_data  = alu_data_i;
    if (alu_wr) begin
      sel_valid = 1'b1;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_addr  = fifo_dout[FW-1:DW];
      sel_data  = fifo_dout[DW-1:0];
    end else if (direct_ld) begin
      sel_valid = 1'b1;
      sel_addr  = mem_rd_i;
      sel_data  = mem_data_i;
    end
  end

  // Registered write port: the selected result appears one cycle later.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      data_o    <= '0;
    end else begin
      wr_en_o <= sel_valid;
      if (sel_valid) begin
        wr_addr_o <= sel_addr;
        data_o    <= sel_data;
      end
    end
  end

  // Next pending set: retire the register being written, then mark new issue (set wins).
  always_comb begin
    pend_d = pend_q;
    if (wr_en_o)   pend_d[wr_addr_o]  = 1'b0;
    if (issue_set) pend_d[issue_rd_i] = 1'b1;
    pend_d[REG_PC] = 1'b0;
  end

  // Pending scoreboard register.
  always_ff @(posedge clk_i) begin
    if (reset_i) pend_q <= '0;
    else         pend_q <= pend_d;
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: directed vector table, hand-written reset
// sequence and randomized traffic against a queue-based reference model.
module tb_reg_writeback_ctrl;

  localparam int DW       = 32;
  localparam int WB_DEPTH = 2;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          issue_valid_i, issue_wr_i, r1_used_i, r2_used_i;
  logic [3:0]    issue_rd_i, r1_addr_i, r2_addr_i;
  logic          alu_valid_i, mem_valid_i;
  logic [3:0]    alu_rd_i, mem_rd_i;
  logic [DW-1:0] alu_data_i, mem_data_i;
  logic          mem_ready_o, stall_o, wr_en_o;
  logic [3:0]    wr_addr_o;
  logic [DW-1:0] data_o;

  int total = 0;
  int bad   = 0;

  reg_writeback_ctrl #(.DW(DW), .NREG(16), .WB_DEPTH(WB_DEPTH)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .issue_valid_i (issue_valid_i),
    .issue_wr_i    (issue_wr_i),
    .issue_rd_i    (issue_rd_i),
    .r1_used_i     (r1_used_i),
    .r1_addr_i     (r1_addr_i),
    .r2_used_i     (r2_used_i),
    .r2_addr_i     (r2_addr_i),
    .alu_valid_i   (alu_valid_i),
    .alu_rd_i      (alu_rd_i),
    .alu_data_i    (alu_data_i),
    .mem_valid_i   (mem_valid_i),
    .mem_rd_i      (mem_rd_i),
    .mem_data_i    (mem_data_i),
    .mem_ready_o   (mem_ready_o),
    .stall_o       (stall_o),
    .wr_en_o       (wr_en_o),
    .wr_addr_o     (wr_addr_o),
    .data_o        (data_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model state ----------------
  bit          m_pend [16];
  logic [35:0] m_buf[$];   // loads waiting for the port, oldest first
  logic [35:0] exp_q[$];   // scoreboard: write expected on the port next cycle
  bit          m_known = 1'b0;

  typedef struct {
    logic iv, iw; logic [3:0] ird;
    logic r1u; logic [3:0] r1; logic r2u; logic [3:0] r2;
    logic av; logic [3:0] ard; logic [31:0] ad;
    logic mv; logic [3:0] mrd; logic [31:0] md;
    logic e_stall, e_ready, e_wr; logic [3:0] e_addr; logic [31:0] e_data;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(
    input logic iv, input logic iw, input logic [3:0] ird,
    input logic r1u, input logic [3:0] r1, input logic r2u, input logic [3:0] r2,
    input logic av, input logic [3:0] ard, input logic [31:0] ad,
    input logic mv, input logic [3:0] mrd, input logic [31:0] md,
    input logic es, input logic er, input logic ew, input logic [3:0] ea, input logic [31:0] ed);
    vec_t v;
    v.iv = iv; v.iw = iw; v.ird = ird; v.r1u = r1u; v.r1 = r1; v.r2u = r2u; v.r2 = r2;
    v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md;
    v.e_stall = es; v.e_ready = er; v.e_wr = ew; v.e_addr = ea; v.e_data = ed;
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    issue_valid_i = 0; issue_wr_i = 0; issue_rd_i = 0;
    r1_used_i = 0; r1_addr_i = 0; r2_used_i = 0; r2_addr_i = 0;
    alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
    mem_valid_i = 0; mem_rd_i = 0; mem_data_i = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    issue_valid_i = v.iv; issue_wr_i = v.iw; issue_rd_i = v.ird;
    r1_used_i = v.r1u; r1_addr_i = v.r1; r2_used_i = v.r2u; r2_addr_i = v.r2;
    alu_valid_i = v.av; alu_rd_i = v.ard; alu_data_i = v.ad;
    mem_valid_i = v.mv; mem_rd_i = v.mrd; mem_data_i = v.md;
  endtask

  // Waits for the sampling edge, compares DUT against the model, advances the model.
  task automatic tick();
    logic [35:0] e;
    logic        e_stall, e_ready, take, direct;
    @(negedge clk_i);
    e_stall = issue_valid_i && ((r1_used_i && m_pend[r1_addr_i]) ||
                                (r2_used_i && m_pend[r2_addr_i]) ||
                                (issue_wr_i && m_pend[issue_rd_i]));
    e_ready = (m_buf.size() < WB_DEPTH);
    if (m_known) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_en", wr_en_o, 1);
        chk("wr_addr", wr_addr_o, e[35:32]);
        chk("wr_data", data_o, e[31:0]);
        m_pend[e[35:32]] = 1'b0;
      end else begin
        chk("wr_en_idle", wr_en_o, 0);
      end
      chk("stall", stall_o, e_stall);
      chk("mem_ready", mem_ready_o, e_ready);
    end
    if (reset_i) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_buf.delete();
      exp_q.delete();
      m_known = 1'b1;
    end else begin
      if (issue_valid_i && !e_stall && issue_wr_i && issue_rd_i != 4'd15)
        m_pend[issue_rd_i] = 1'b1;
      take   = mem_valid_i && e_ready && mem_rd_i != 4'd15;
      direct = 1'b0;
      if (alu_valid_i && alu_rd_i != 4'd15) exp_q.push_back({alu_rd_i, alu_data_i});
      else if (m_buf.size() != 0)           exp_q.push_back(m_buf.pop_front());
      else if (take) begin
        exp_q.push_back({mem_rd_i, mem_data_i});
        direct = 1'b1;
      end
      if (take && !direct) m_buf.push_back({mem_rd_i, mem_data_i});
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      drive_idle();
      reset_i = 1'b1;
      tick();
      next_cycle();
    end
    reset_i = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset_i = 1'b1;
    drive_idle();
    #1;

    // 1: reset, then nothing pending or written
    do_reset(2);
    drive_idle();
    issue_valid_i = 1; r1_used_i = 1; r1_addr_i = 5; r2_used_i = 1; r2_addr_i = 9;
    tick();
    chk("t1_wr_en", wr_en_o, 0);
    chk("t1_stall", stall_o, 0);
    chk("t1_ready", mem_ready_o, 1);
    next_cycle();

    // 2-5 and direct-load / r2 / WAW cases as a cycle-by-cycle table
    tbl[0]  = mk(1,1,3, 0,0,0,0, 0,0,0,            0,0,0,        0,1,0,0,0);
    tbl[1]  = mk(1,0,0, 1,3,0,0, 1,3,32'hDEADBEEF, 0,0,0,        1,1,0,0,0);
    tbl[2]  = mk(1,0,0, 1,3,0,0, 0,0,0,            0,0,0,        1,1,1,3,32'hDEADBEEF);
    tbl[3]  = mk(1,0,0, 1,3,0,0, 0,0,0,            0,0,0,        0,1,0,0,0);
    tbl[4]  = mk(0,0,0, 0,0,0,0, 1,4,32'h44,       1,5,32'h55,   0,1,0,0,0);
    tbl[5]  = mk(0,0,0, 0,0,0,0, 0,0,0,            0,0,0,        0,1,1,4,32'h44);
    tbl[6]  = mk(0,0,0, 0,0,0,0, 0,0,0,            0,0,0,        0,1,1,5,32'h55);
    tbl[7]  = mk(0,0,0, 0,0,0,0, 1,7,32'h70,       1,8,32'h80,   0,1,0,0,0);
    tbl[8]  = mk(0,0,0, 0,0,0,0, 1,7,32'h71,       1,9,32'h90,   0,1,1,7,32'h70);
    tbl[9]  = mk(0,0,0, 0,0,0,0, 1,7,32'h72,       1,10,32'hA0,  0,0,1,7,32'h71);
    tbl[10] = mk(0,0,0, 0,0,0,0, 1,7,32'h73,       1,10,32'hA0,  0,0,1,7,32'h72);
    tbl[11] = mk(0,0,0, 0,0,0,0, 0,0,0,            1,10,32'hA0,  0,0,1,7,32'h73);
    tbl[12] = mk(0,0,0, 0,0,0,0, 0,0,0,            1,10,32'hA0,  0,1,1,8,32'h80);
    tbl[13] = mk(0,0,0, 0,0,0,0, 0,0,0,            0,0,0,        0,1,1,9,32'h90);
    tbl[14] = mk(0,0,0, 0,0,0,0, 0,0,0,            0,0,0,        0,1,1,10,32'hA0);
    tbl[15] = mk(1,1,15,0,0,0,0, 1,15,32'h100,     0,0,0,        0,1,0,0,0);
    tbl[16] = mk(1,1,15,1,15,0,0,0,0,0,            0,0,0,        0,1,0,0,0);
    tbl[17] = mk(0,0,0, 0,0,0,0, 0,0,0,            1,11,32'hB0,  0,1,0,0,0);
    tbl[18] = mk(0,0,0, 0,0,0,0, 0,0,0,            1,15,32'h150, 0,1,1,11,32'hB0);
    tbl[19] = mk(1,1,2, 0,0,0,0, 0,0,0,            0,0,0,        0,1,0,0,0);
    tbl[20] = mk(1,0,0, 0,0,1,2, 0,0,0,            0,0,0,        1,1,0,0,0);
    tbl[21] = mk(1,1,2, 0,0,0,0, 0,0,0,            0,0,0,        1,1,0,0,0);
    tbl[22] = mk(1,0,0, 0,0,1,2, 0,0,0,            1,2,32'h22,   1,1,0,0,0);
    tbl[23] = mk(1,0,0, 0,0,1,2, 0,0,0,            0,0,0,        1,1,1,2,32'h22);
    tbl[24] = mk(1,0,0, 0,0,1,2, 0,0,0,            0,0,0,        0,1,0,0,0);

    for (int i = 0; i < 25; i++) begin
      drive_vec(tbl[i]);
      tick();
      chk($sformatf("tbl%0d_stall", i), stall_o, tbl[i].e_stall);
      chk($sformatf("tbl%0d_ready", i), mem_ready_o, tbl[i].e_ready);
      chk($sformatf("tbl%0d_wr_en", i), wr_en_o, tbl[i].e_wr);
      if (tbl[i].e_wr) begin
        chk($sformatf("tbl%0d_addr", i), wr_addr_o, tbl[i].e_addr);
        chk($sformatf("tbl%0d_data", i), data_o, tbl[i].e_data);
      end
      next_cycle();
    end

    // 6: reset while two loads are buffered and r6 is pending
    drive_idle(); issue_valid_i = 1; issue_wr_i = 1; issue_rd_i = 6;
    tick(); next_cycle();
    drive_idle(); alu_valid_i = 1; alu_rd_i = 1; alu_data_i = 32'h1;
    mem_valid_i = 1; mem_rd_i = 12; mem_data_i = 32'hC;
    tick(); next_cycle();
    drive_idle(); alu_valid_i = 1; alu_rd_i = 1; alu_data_i = 32'h2;
    mem_valid_i = 1; mem_rd_i = 13; mem_data_i = 32'hD;
    tick(); next_cycle();
    drive_idle(); reset_i = 1'b1;
    tick();
    chk("t6_full_before_reset", mem_ready_o, 0);
    next_cycle();
    tick(); next_cycle();
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_idle(); issue_valid_i = 1; r1_used_i = 1; r1_addr_i = 6;
      tick();
      chk($sformatf("t6_wr_en%0d", i), wr_en_o, 0);
      chk($sformatf("t6_stall%0d", i), stall_o, 0);
      chk($sformatf("t6_ready%0d", i), mem_ready_o, 1);
      next_cycle();
    end

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      drive_idle();
      issue_valid_i = 1'($urandom_range(0, 1));
      issue_wr_i    = 1'($urandom_range(0, 1));
      issue_rd_i    = 4'($urandom_range(0, 15));
      r1_used_i     = 1'($urandom_range(0, 1));
      r1_addr_i     = 4'($urandom_range(0, 15));
      r2_used_i     = 1'($urandom_range(0, 1));
      r2_addr_i     = 4'($urandom_range(0, 15));
      alu_valid_i   = ($urandom_range(0, 9) < 4);
      alu_rd_i      = 4'($urandom_range(0, 15));
      alu_data_i    = $urandom;
      mem_valid_i   = ($urandom_range(0, 9) < 5);
      mem_rd_i      = 4'($urandom_range(0, 15));
      mem_data_i    = $urandom;
      reset_i       = ($urandom_range(0, 127) == 0);
      tick();
      next_cycle();
    end
    reset_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_idle();
      tick();
      next_cycle();
    end
    chk("drain_exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
